// File: rtl/pos_equiv_sweeper.sv
// pos_equiv_sweeper: walks every input minterm, holds it for a settle time,
// samples a reference function and its minimized counterpart, and records
// the reference truth table, the mismatch count and the first failing minterm.
module pos_equiv_sweeper #(
  parameter int N_VARS     = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     f_ref,
  input  logic                     f_min,
  output logic [N_VARS-1:0]        vec,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_VARS:0]          mismatch_cnt,
  output logic [N_VARS-1:0]        first_fail,
  output logic                     first_fail_valid,
  output logic [(1<<N_VARS)-1:0]   truth_table
);

  localparam int                N_MIN       = 1 << N_VARS;
  localparam logic [N_VARS-1:0] LAST_VEC    = N_VARS'(N_MIN - 1);
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection plus the status outputs decoded from the state.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (abort)                 state_nxt = S_IDLE;
        else if (settle_cnt == '0) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)                 state_nxt = S_IDLE;
        else if (vec == LAST_VEC)  state_nxt = S_DONE;
        else                       state_nxt = S_SETTLE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Vector, settle timer and result registers; abort wins over sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec              <= '0;
      settle_cnt       <= '0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      truth_table      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vec              <= '0;
            settle_cnt       <= SETTLE_LOAD;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            truth_table      <= '0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            vec  <= '0;
            pass <= 1'b0;
          end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            vec  <= '0;
            pass <= 1'b0;
          end else begin
            truth_table[vec] <= f_ref;
            if (f_ref != f_min) begin
              mismatch_cnt <= mismatch_cnt + 1'b1;
              if (!first_fail_valid) begin
                first_fail       <= vec;
                first_fail_valid <= 1'b1;
              end
            end
            if (vec != LAST_VEC) begin
              vec        <= vec + 1'b1;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        S_DONE: begin
          pass <= (mismatch_cnt == '0);
          vec  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_equiv_sweeper.sv
// tb_pos_equiv_sweeper: directed bench for the equivalence sweeper, driving a
// PoS function with zeros at minterms 1,5,7 (truth table 8'h5D) and variants.
module tb_pos_equiv_sweeper;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, start3, abort3;
  logic       f_ref, f_min, f_ref3, f_min3;
  logic [2:0] vec, vec3, first_fail, first_fail3;
  logic       busy, done, pass, first_fail_valid;
  logic       busy3, done3, pass3, first_fail_valid3;
  logic [3:0] mismatch_cnt, mismatch_cnt3;
  logic [7:0] truth_table, truth_table3;

  int mode;
  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  pos_equiv_sweeper #(.N_VARS(3), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f_ref(f_ref), .f_min(f_min), .vec(vec), .busy(busy), .done(done),
    .pass(pass), .mismatch_cnt(mismatch_cnt), .first_fail(first_fail),
    .first_fail_valid(first_fail_valid), .truth_table(truth_table)
  );

  pos_equiv_sweeper #(.N_VARS(3), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .f_ref(f_ref3), .f_min(f_min3), .vec(vec3), .busy(busy3), .done(done3),
    .pass(pass3), .mismatch_cnt(mismatch_cnt3), .first_fail(first_fail3),
    .first_fail_valid(first_fail_valid3), .truth_table(truth_table3)
  );

  function automatic logic pos_fn(input logic [2:0] v);
    return (v[2] | v[1] | ~v[0]) & (~v[2] | v[1] | ~v[0]) & (~v[2] | ~v[1] | ~v[0]);
  endfunction

  // mode 0: equivalent, 1: f_min tied low, 2: f_min inverted at minterm 6
  function automatic logic min_fn(input logic [2:0] v, input int m);
    case (m)
      1:       return 1'b0;
      2:       return pos_fn(v) ^ (v == 3'd6);
      default: return pos_fn(v);
    endcase
  endfunction

  always_comb begin
    f_ref  = pos_fn(vec);
    f_min  = min_fn(vec, mode);
    f_ref3 = pos_fn(vec3);
    f_min3 = min_fn(vec3, mode);
  end

  // Starts a sweep on dut; reports latency to done (-1 if none) and pulse count.
  task automatic run_sweep(input int restart_at, output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == restart_at);
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (lat < 0) lat = c;
      end
      if (lat > 0 && c >= lat + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0; mode = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({vec, busy, done, pass, mismatch_cnt, first_fail, first_fail_valid, truth_table} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got vec=%0d busy=%b done=%b pass=%b mc=%0d ff=%0d ffv=%b tt=%h, want all zero",
               vec, busy, done, pass, mismatch_cnt, first_fail, first_fail_valid, truth_table);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_equivalent();
    int lat, pulses;
    mode = 0;
    run_sweep(0, lat, pulses);
    vectors++; if (lat !== 16)    begin miscompares++; $display("[TB] FAIL eq_latency: got %0d, want 16", lat); end
    vectors++; if (pulses !== 1)  begin miscompares++; $display("[TB] FAIL eq_pulses: got %0d, want 1", pulses); end
    vectors++; if (truth_table !== 8'h5D) begin miscompares++; $display("[TB] FAIL eq_tt: got %h, want 5d", truth_table); end
    vectors++; if (mismatch_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL eq_mc: got %0d, want 0", mismatch_cnt); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("[TB] FAIL eq_pass: got %b, want 1", pass); end
    vectors++; if (first_fail_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL eq_ffv: got %b, want 0", first_fail_valid); end
    vectors++; if (busy !== 1'b0 || vec !== 3'd0) begin miscompares++; $display("[TB] FAIL eq_idle: got busy=%b vec=%0d, want 0/0", busy, vec); end
  endtask

  task automatic test_all_mismatch();
    int lat, pulses;
    mode = 1;
    run_sweep(0, lat, pulses);
    vectors++; if (lat !== 16) begin miscompares++; $display("[TB] FAIL zero_latency: got %0d, want 16", lat); end
    vectors++; if (mismatch_cnt !== 4'd5) begin miscompares++; $display("[TB] FAIL zero_mc: got %0d, want 5", mismatch_cnt); end
    vectors++; if (first_fail !== 3'd0 || first_fail_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_ff: got %0d/%b, want 0/1", first_fail, first_fail_valid); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_pass: got %b, want 0", pass); end
    vectors++; if (truth_table !== 8'h5D) begin miscompares++; $display("[TB] FAIL zero_tt: got %h, want 5d", truth_table); end
  endtask

  task automatic test_single_mismatch();
    int lat, pulses;
    mode = 2;
    run_sweep(0, lat, pulses);
    vectors++; if (mismatch_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL one_mc: got %0d, want 1", mismatch_cnt); end
    vectors++; if (first_fail !== 3'd6 || first_fail_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL one_ff: got %0d/%b, want 6/1", first_fail, first_fail_valid); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("[TB] FAIL one_pass: got %b, want 0", pass); end
  endtask

  task automatic test_slow_settle();
    int lat;
    mode = 2;
    lat  = -1;
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (done3) lat = c;
    end
    vectors++; if (lat !== 32) begin miscompares++; $display("[TB] FAIL slow_latency: got %0d, want 32", lat); end
    @(posedge clk);
    #1;
    vectors++; if (mismatch_cnt3 !== 4'd1 || first_fail3 !== 3'd6 || pass3 !== 1'b0 || truth_table3 !== 8'h5D)
      begin miscompares++; $display("[TB] FAIL slow_results: got mc=%0d ff=%0d pass=%b tt=%h, want 1/6/0/5d", mismatch_cnt3, first_fail3, pass3, truth_table3); end
  endtask

  task automatic test_start_ignored();
    int lat, pulses;
    mode = 0;
    run_sweep(5, lat, pulses);
    vectors++; if (lat !== 16)   begin miscompares++; $display("[TB] FAIL restart_latency: got %0d, want 16", lat); end
    vectors++; if (pulses !== 1) begin miscompares++; $display("[TB] FAIL restart_pulses: got %0d, want 1", pulses); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_pass: got %b, want 1", pass); end
  endtask

  task automatic test_abort();
    int lat, pulses, seen, dones;
    mode  = 1;
    seen  = 0;
    dones = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (vec == 3'd3) seen = 1;
    end
    vectors++; if (seen !== 1) begin miscompares++; $display("[TB] FAIL abort_reach_vec3: got %0d, want 1", seen); end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    vectors++; if (busy !== 1'b0 || vec !== 3'd0 || done !== 1'b0 || pass !== 1'b0)
      begin miscompares++; $display("[TB] FAIL abort_state: got busy=%b vec=%0d done=%b pass=%b, want 0/0/0/0", busy, vec, done, pass); end
    vectors++; if (mismatch_cnt !== 4'd2 || truth_table !== 8'h05)
      begin miscompares++; $display("[TB] FAIL abort_partial: got mc=%0d tt=%h, want 2/05", mismatch_cnt, truth_table); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    vectors++; if (dones !== 0) begin miscompares++; $display("[TB] FAIL abort_no_done: got %0d pulses, want 0", dones); end
    mode = 0;
    run_sweep(0, lat, pulses);
    vectors++; if (lat !== 16 || mismatch_cnt !== 4'd0 || pass !== 1'b1 || truth_table !== 8'h5D)
      begin miscompares++; $display("[TB] FAIL abort_rerun: got lat=%0d mc=%0d pass=%b tt=%h, want 16/0/1/5d", lat, mismatch_cnt, pass, truth_table); end
  endtask

  task automatic test_async_reset();
    int lat, pulses, seen;
    mode  = 1;
    seen  = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (vec == 3'd4) seen = 1;
    end
    vectors++; if (seen !== 1) begin miscompares++; $display("[TB] FAIL rst_reach_vec4: got %0d, want 1", seen); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({vec, busy, done, pass, mismatch_cnt, first_fail, first_fail_valid, truth_table} !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_async: got vec=%0d busy=%b mc=%0d ff=%0d ffv=%b tt=%h, want all zero",
               vec, busy, mismatch_cnt, first_fail, first_fail_valid, truth_table);
    end
    @(negedge clk) rst_n = 1'b1;
    mode = 2;
    run_sweep(0, lat, pulses);
    vectors++; if (lat !== 16 || mismatch_cnt !== 4'd1 || first_fail !== 3'd6 || truth_table !== 8'h5D)
      begin miscompares++; $display("[TB] FAIL rst_rerun: got lat=%0d mc=%0d ff=%0d tt=%h, want 16/1/6/5d", lat, mismatch_cnt, first_fail, truth_table); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_equivalent();
    test_all_mismatch();
    test_single_mismatch();
    test_slow_settle();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pos_equiv_sweeper.md
Name: pos_equiv_sweeper

Overview:
Sequencer that checks two 3-input combinational functions for equivalence: a canonical product-of-sums form and its minimized form. It walks every input combination (minterm 0..2^N_VARS-1), waits a settle time, samples both function outputs, and records the reference truth table, the mismatch count and the first failing minterm. It replaces the hand-written for-loop benches for the PoS/minimization exercises and can drive any pair of function modules wired to its vector output.

Parameters:
N_VARS, 3, number of function inputs; sweep covers 2^N_VARS minterms
SETTLE_CYC, 1, cycles the vector is held before sampling; legal range 1..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  cancel a running sweep
f_ref  input  1  output of the canonical (PoS) function under test
f_min  input  1  output of the minimized function under test
vec  output  N_VARS  applied input vector {x,y,z}, MSB = x
busy  output  1  high from accepted start until the DONE cycle
done  output  1  one-cycle pulse when a sweep completes normally
pass  output  1  1 when the last completed sweep had zero mismatches
mismatch_cnt  output  N_VARS+1  number of minterms where f_ref != f_min
first_fail  output  N_VARS  lowest minterm that mismatched
first_fail_valid  output  1  first_fail holds a valid value
truth_table  output  2^N_VARS  bit i = f_ref sampled at minterm i

Behaviour:
- Reset (rst_n low, async): state IDLE; vec=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail=0, first_fail_valid=0, truth_table=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 at an edge -> SETTLE; same edge clears mismatch_cnt, first_fail, first_fail_valid, truth_table, pass; vec=0; busy=1; settle counter loaded with SETTLE_CYC-1.
- SETTLE: vec held. Counter==0 -> SAMPLE, else decrement. Duration SETTLE_CYC cycles.
- SAMPLE (1 cycle): truth_table[vec] <= f_ref. If f_ref != f_min: mismatch_cnt++; if first_fail_valid==0, first_fail <= vec and first_fail_valid <= 1. If vec == 2^N_VARS-1 -> DONE; else vec <= vec+1, counter reloaded, -> SETTLE.
- DONE (1 cycle): done=1, busy=1; pass <= (mismatch_cnt==0); vec <= 0; -> IDLE. busy drops on the following edge.
- Latency: start accepted at edge k -> done high for the cycle after edge k + 2^N_VARS*(SETTLE_CYC+1). Defaults: 16 cycles.
- Results (truth_table, mismatch_cnt, first_fail*, pass) hold until the next accepted start or reset.
- start while not in IDLE: ignored, no restart.
- abort=1 in SETTLE or SAMPLE: -> IDLE next edge; busy=0, vec=0, done never pulses, pass=0; partial truth_table/mismatch_cnt left as-is. abort has priority over SAMPLE updates in the same cycle. abort in IDLE/DONE: ignored (DONE still completes).
- start and abort both high in IDLE: start wins.
- mismatch_cnt cannot overflow: width N_VARS+1 holds 2^N_VARS.
- vec changes only on SAMPLE->SETTLE, DONE and abort transitions; never wraps past 2^N_VARS-1.
- Reset asserted mid-sweep: immediate return to reset values; no done pulse.

Test Plan:
- f_ref and f_min both driven by PoS with zeros at minterms 1,5,7; pulse start -> done exactly 16 cycles after accepted start, truth_table=8'h5D, mismatch_cnt=0, pass=1, first_fail_valid=0.
- f_ref = same PoS, f_min tied 0 -> mismatch_cnt=5, first_fail=0, first_fail_valid=1, pass=0, truth_table=8'h5D.
- f_min = PoS output inverted only at minterm 6 -> mismatch_cnt=1, first_fail=6, pass=0; rerun with SETTLE_CYC=3 -> done 32 cycles after start, same results.
- Pulse start again at cycle 5 of a running sweep -> ignored; done still at cycle 16, single done pulse.
- abort at vec=3 during SETTLE -> busy=0 and vec=0 next cycle, no done pulse, pass=0; new start then completes normally with fresh results.
- Drop rst_n asynchronously mid-SETTLE at vec=4 -> all outputs zero immediately (before next clk edge); sweep after release gives correct results.
